// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port arbiter and sequencer in front of the
// byte-addressed data memory. Each granted access runs IDLE -> ACCESS -> RESP;
// misaligned or illegal-width accesses are rejected without a memory write.
module data_mem_arbiter #(
    parameter int WA = 32,
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Req0,
    input  logic          Req1,
    input  logic [WA-1:0] Addr0,
    input  logic [WA-1:0] Addr1,
    input  logic          Write0,
    input  logic          Write1,
    input  logic [2:0]    Funct30,
    input  logic [2:0]    Funct31,
    input  logic [WD-1:0] WData0,
    input  logic [WD-1:0] WData1,
    output logic          Ack0,
    output logic          Ack1,
    output logic          Err0,
    output logic          Err1,
    output logic [WD-1:0] RData0,
    output logic [WD-1:0] RData1,
    output logic [WA-1:0] MemAddr,
    output logic          MemWrite,
    output logic [2:0]    MemFunct3,
    output logic [WD-1:0] MemWData,
    input  logic [WD-1:0] MemRData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          owner;
    logic          pri;
    logic [WA-1:0] addr_q;
    logic          write_q;
    logic [2:0]    f3_q;
    logic [WD-1:0] wdata_q;
    logic          bad_q;

    logic          grant;
    logic          win;
    logic [WA-1:0] sel_addr;
    logic          sel_write;
    logic [2:0]    sel_f3;
    logic [WD-1:0] sel_wdata;

    // Reject widths the memory cannot perform and accesses not naturally aligned.
    function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (f3[1:0] == 2'b11)
            bad = 1'b1;
        if (f3[1:0] == 2'b10 && a != 2'b00)
            bad = 1'b1;
        if (f3[1:0] == 2'b01 && a[0])
            bad = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
            bad = 1'b1;
        return bad;
    endfunction

    // Winner: the sole requester, or the preferred port when both request.
    assign grant     = Req0 | Req1;
    assign win       = (Req0 & Req1) ? pri : Req1;
    assign sel_addr  = win ? Addr1   : Addr0;
    assign sel_write = win ? Write1  : Write0;
    assign sel_f3    = win ? Funct31 : Funct30;
    assign sel_wdata = win ? WData1  : WData0;

    // Sequencer: latch the winner in IDLE, perform the access, then respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            pri     <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            f3_q    <= 3'b000;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            RData0  <= '0;
            RData1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        addr_q  <= sel_addr;
                        write_q <= sel_write;
                        f3_q    <= sel_f3;
                        wdata_q <= sel_wdata;
                        bad_q   <= access_bad(sel_f3, sel_addr[1:0]);
                        owner   <= win;
                        pri     <= ~win;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!write_q && !bad_q) begin
                        if (owner)
                            RData1 <= MemRData;
                        else
                            RData0 <= MemRData;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory strobe and completion flags decoded straight from registers, so a
    // reset during ACCESS removes the write strobe before the next edge.
    assign MemWrite  = (state == ACCESS) & write_q & ~bad_q;
    assign MemAddr   = addr_q;
    assign MemFunct3 = f3_q;
    assign MemWData  = wdata_q;
    assign Ack0      = (state == RESP) & ~owner;
    assign Ack1      = (state == RESP) &  owner;
    assign Err0      = Ack0 & bad_q;
    assign Err1      = Ack1 & bad_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a small data
// memory, a transaction-level reference model and a per-cycle output compare.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0;
    logic        Write0 = 1'b0, Write1 = 1'b0;
    logic [31:0] Addr0 = '0, Addr1 = '0, WData0 = '0, WData1 = '0;
    logic [2:0]  Funct30 = '0, Funct31 = '0;
    logic        Ack0, Ack1, Err0, Err1, MemWrite;
    logic [31:0] RData0, RData1, MemAddr, MemWData, MemRData;
    logic [2:0]  MemFunct3;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;

    data_mem_arbiter #(.WA(32), .WD(32)) dut (
        .clk(clk), .rst(rst),
        .Req0(Req0), .Req1(Req1), .Addr0(Addr0), .Addr1(Addr1),
        .Write0(Write0), .Write1(Write1), .Funct30(Funct30), .Funct31(Funct31),
        .WData0(WData0), .WData1(WData1),
        .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
        .RData0(RData0), .RData1(RData1),
        .MemAddr(MemAddr), .MemWrite(MemWrite), .MemFunct3(MemFunct3),
        .MemWData(MemWData), .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Byte-lane load with RISC-V sign/zero extension.
    function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // Byte-lane store merge.
    function automatic logic [31:0] st(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f,
                                       input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (f[1:0])
            2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
            2'b01:   if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    // An access is legal only as a byte, an even-address half or an aligned word.
    function automatic logic legal(input logic [2:0] f, input logic [31:0] a);
        if (f == 3'b000 || f == 3'b100) return 1'b1;
        if ((f == 3'b001 || f == 3'b101) && a[0] == 1'b0) return 1'b1;
        if (f == 3'b010 && a[1:0] == 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // Data memory attached to the DUT; combinational read, write at the edge.
    logic [31:0] emem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_dat = '0;

    assign MemRData = ld(emem[MemAddr[9:2]], MemAddr[1:0], MemFunct3);

    always @(posedge clk) begin
        if (pre_we)
            emem[pre_idx] <= pre_dat;
        else if (MemWrite)
            emem[MemAddr[9:2]] <= st(emem[MemAddr[9:2]], MemAddr[1:0], MemFunct3, MemWData);
    end

    // Reference model: on a grant at the edge ending cycle g, the access occupies
    // cycle g+1, the response cycle g+2, and the next grant can come at the edge
    // ending cycle g+3.
    logic [31:0] mmem [0:255];
    int          acc_cyc = -1, resp_cyc = -1, busy_until = 0;
    logic        m_pri = 1'b0, t_owner = 1'b0, t_write = 1'b0, t_bad = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0, m_rd0 = '0, m_rd1 = '0;
    logic [2:0]  t_f3 = '0;
    logic        m_win;

    assign m_win = (Req0 && Req1) ? m_pri : Req1;

    always @(posedge clk or posedge rst) begin
        if (pre_we)
            mmem[pre_idx] <= pre_dat;
        if (rst) begin
            acc_cyc    <= -1;
            resp_cyc   <= -1;
            busy_until <= 0;
            m_pri      <= 1'b0;
            t_owner    <= 1'b0;
            t_write    <= 1'b0;
            t_bad      <= 1'b0;
            m_rd0      <= '0;
            m_rd1      <= '0;
        end else begin
            if (cyc == acc_cyc && !t_bad) begin
                if (t_write)
                    mmem[t_addr[9:2]] <= st(mmem[t_addr[9:2]], t_addr[1:0], t_f3, t_wdata);
                else if (t_owner)
                    m_rd1 <= ld(mmem[t_addr[9:2]], t_addr[1:0], t_f3);
                else
                    m_rd0 <= ld(mmem[t_addr[9:2]], t_addr[1:0], t_f3);
            end
            if (cyc >= busy_until && (Req0 || Req1)) begin
                t_owner    <= m_win;
                m_pri      <= !m_win;
                t_addr     <= m_win ? Addr1 : Addr0;
                t_write    <= m_win ? Write1 : Write0;
                t_f3       <= m_win ? Funct31 : Funct30;
                t_wdata    <= m_win ? WData1 : WData0;
                t_bad      <= !legal(m_win ? Funct31 : Funct30, m_win ? Addr1 : Addr0);
                acc_cyc    <= cyc + 1;
                resp_cyc   <= cyc + 2;
                busy_until <= cyc + 3;
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        chk("MemWrite", MemWrite, (cyc == acc_cyc) && t_write && !t_bad);
        chk("Ack0", Ack0, (cyc == resp_cyc) && !t_owner);
        chk("Ack1", Ack1, (cyc == resp_cyc) && t_owner);
        chk("Err0", Err0, (cyc == resp_cyc) && !t_owner && t_bad);
        chk("Err1", Err1, (cyc == resp_cyc) && t_owner && t_bad);
        chk("RData0", RData0, m_rd0);
        chk("RData1", RData1, m_rd1);
        if (cyc == acc_cyc) begin
            chk("MemAddr", MemAddr, t_addr);
            chk("MemFunct3", {29'b0, MemFunct3}, {29'b0, t_f3});
            if (t_write && !t_bad)
                chk("MemWData", MemWData, t_wdata);
        end
    end

    task automatic setp(input int p, input logic r, input logic [31:0] a, input logic w,
                        input logic [2:0] f, input logic [31:0] d);
        if (p == 0) begin
            Req0 = r; Addr0 = a; Write0 = w; Funct30 = f; WData0 = d;
        end else begin
            Req1 = r; Addr1 = a; Write1 = w; Funct31 = f; WData1 = d;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_we  = 1'b1;
        pre_idx = a[9:2];
        pre_dat = d;
        @(posedge clk); #1;
        pre_we  = 1'b0;
    endtask

    // One transaction from IDLE: raise Req, wait (bounded) for Ack, drop Req
    // in the cycle after Ack. Reports Err, write-strobe cycles and latency.
    task automatic xact(input int p, input logic [31:0] a, input logic w, input logic [2:0] f,
                        input logic [31:0] d, output logic err, output int mw, output int lat);
        logic got;
        got = 1'b0; mw = 0; lat = 0; err = 1'b0;
        setp(p, 1'b1, a, w, f, d);
        for (int i = 1; i <= 12 && !got; i++) begin
            @(posedge clk); #1;
            if (MemWrite) mw++;
            if ((p == 0) ? Ack0 : Ack1) begin
                got = 1'b1;
                lat = i;
                err = (p == 0) ? Err0 : Err1;
            end
        end
        chk("ack_timeout", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        setp(p, 1'b0, a, w, f, d);
    endtask

    logic        err;
    int          mw, lat, n, first, acks;
    int          own [8];
    int          at  [8];
    logic        d0, d1;
    logic [31:0] bad_a [3] = '{32'h82, 32'h41, 32'h80};
    logic        bad_w [3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0]  bad_f [3] = '{3'b010, 3'b001, 3'b011};

    initial begin
        rst = 1'b1;
        preload(32'h40, 32'hDEADBEEF);
        preload(32'h80, 32'h00000000);
        preload(32'h90, 32'h11111111);
        chk("rst_Ack0", {31'b0, Ack0}, 32'd0);
        chk("rst_Ack1", {31'b0, Ack1}, 32'd0);
        chk("rst_MemWrite", {31'b0, MemWrite}, 32'd0);
        chk("rst_RData0", RData0, 32'd0);
        chk("rst_MemAddr", MemAddr, 32'd0);
        rst = 1'b0;

        // Contention from reset: both ports hold Req for 8 grants in total.
        setp(0, 1'b1, 32'h40, 1'b0, 3'b010, 32'h0);
        setp(1, 1'b1, 32'h40, 1'b0, 3'b010, 32'h0);
        n = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            @(posedge clk); #1;
            if (Ack0 || Ack1) begin
                own[n] = Ack1 ? 1 : 0;
                at[n]  = cyc;
                n++;
            end
        end
        chk("contention_count", n, 32'd8);
        @(posedge clk); #1;
        setp(0, 1'b0, 32'h40, 1'b0, 3'b010, 32'h0);
        setp(1, 1'b0, 32'h40, 1'b0, 3'b010, 32'h0);
        for (int k = 0; k < n; k++) begin
            chk("grant_order", own[k], k % 2);
            if (k > 0) chk("ack_spacing", at[k] - at[k-1], 32'd3);
        end

        // Single load, port 0.
        xact(0, 32'h40, 1'b0, 3'b010, 32'h0, err, mw, lat);
        chk("lw0_latency", lat, 32'd2);
        chk("lw0_err", {31'b0, err}, 32'd0);
        chk("lw0_data", RData0, 32'hDEADBEEF);

        // Store then load, port 1.
        xact(1, 32'h80, 1'b1, 3'b010, 32'h12345678, err, mw, lat);
        chk("sw1_strobe_cycles", mw, 32'd1);
        chk("sw1_err", {31'b0, err}, 32'd0);
        xact(1, 32'h80, 1'b0, 3'b010, 32'h0, err, mw, lat);
        chk("lw1_data", RData1, 32'h12345678);
        chk("lw1_rdata0_kept", RData0, 32'hDEADBEEF);

        // Misaligned / illegal accesses on port 0, each followed by a port-1 reload.
        for (int k = 0; k < 3; k++) begin
            xact(0, bad_a[k], bad_w[k], bad_f[k], 32'hBAD0BAD0, err, mw, lat);
            chk("bad_err", {31'b0, err}, 32'd1);
            chk("bad_no_strobe", mw, 32'd0);
            chk("bad_rdata0_kept", RData0, 32'hDEADBEEF);
            xact(1, 32'h80, 1'b0, 3'b010, 32'h0, err, mw, lat);
            chk("bad_reload", RData1, 32'h12345678);
        end

        // Req dropped right after the Ack cycle: no second grant.
        xact(0, 32'h40, 1'b0, 3'b010, 32'h0, err, mw, lat);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (Ack0) acks++;
        end
        chk("no_dup_grant", acks, 32'd0);

        // Req still high in the IDLE cycle after Ack: serviced again.
        setp(0, 1'b1, 32'h80, 1'b0, 3'b010, 32'h0);
        d0 = 1'b0;
        for (int i = 0; i < 12 && !d0; i++) begin
            @(posedge clk); #1;
            if (Ack0) d0 = 1'b1;
        end
        chk("held_first_ack", {31'b0, d0}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        setp(0, 1'b0, 32'h80, 1'b0, 3'b010, 32'h0);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (Ack0) acks++;
        end
        chk("held_second_grant", acks, 32'd1);
        chk("held_data", RData0, 32'h12345678);

        // Reset during ACCESS of a store to 0x90.
        setp(0, 1'b1, 32'h90, 1'b1, 3'b010, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("rst_mid_strobe_on", {31'b0, MemWrite}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_strobe_off", {31'b0, MemWrite}, 32'd0);
        chk("rst_mid_Ack0", {31'b0, Ack0}, 32'd0);
        chk("rst_mid_Err0", {31'b0, Err0}, 32'd0);
        chk("rst_mid_MemAddr", MemAddr, 32'd0);
        chk("rst_mid_RData0", RData0, 32'd0);
        chk("rst_mid_RData1", RData1, 32'd0);
        setp(0, 1'b0, 32'h90, 1'b1, 3'b010, 32'hCAFEF00D);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mem90_unchanged", emem[36], 32'h11111111);

        // Both request after reset: port 0 is preferred.
        setp(0, 1'b1, 32'h90, 1'b0, 3'b010, 32'h0);
        setp(1, 1'b1, 32'h40, 1'b0, 3'b010, 32'h0);
        n = 0; first = -1; d0 = 1'b0; d1 = 1'b0;
        for (int i = 0; i < 12 && n < 2; i++) begin
            @(posedge clk); #1;
            if (d0) begin setp(0, 1'b0, 32'h90, 1'b0, 3'b010, 32'h0); d0 = 1'b0; end
            if (d1) begin setp(1, 1'b0, 32'h40, 1'b0, 3'b010, 32'h0); d1 = 1'b0; end
            if (Ack0) begin if (n == 0) first = 0; n++; d0 = 1'b1; end
            if (Ack1) begin if (n == 0) first = 1; n++; d1 = 1'b1; end
        end
        @(posedge clk); #1;
        setp(0, 1'b0, 32'h90, 1'b0, 3'b010, 32'h0);
        setp(1, 1'b0, 32'h40, 1'b0, 3'b010, 32'h0);
        chk("post_rst_acks", n, 32'd2);
        chk("post_rst_first", first, 32'd0);
        chk("post_rst_rdata0", RData0, 32'h11111111);
        chk("post_rst_rdata1", RData1, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed data memory. It shares the single memory port between the load/store path (port 0) and a secondary master such as a loader or debug port (port 1), using round-robin arbitration. It runs each granted transaction as a fixed three-state sequence and flags misaligned or illegal-width accesses without touching memory. It sits between the requesters and the data memory's ALUResult/MemWrite/funct3/WriteData/ReadData port.

## Interface
Parameters:
- WA, 32, address width
- WD, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- Req0 / Req1  in  1  request from port 0 / port 1; held until the matching Ack
- Addr0 / Addr1  in  WA  byte address
- Write0 / Write1  in  1  1 = store, 0 = load
- Funct30 / Funct31  in  3  access type, RISC-V funct3 encoding
- WData0 / WData1  in  WD  store data
- Ack0 / Ack1  out  1  one-cycle completion pulse
- Err0 / Err1  out  1  valid with Ack; 1 = access rejected
- RData0 / RData1  out  WD  registered load result
- MemAddr  out  WA  to memory ALUResult
- MemWrite  out  1  to memory MemWrite
- MemFunct3  out  3  to memory funct3
- MemWData  out  WD  to memory WriteData
- MemRData  in  WD  from memory ReadData, combinational

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, Owner (1 bit), Pri (1 bit, preferred port), and latched Addr/Write/Funct3/WData/Bad.
- IDLE, no Req: stay in IDLE.
- IDLE, exactly one Req: grant that port.
- IDLE, both Req: grant port Pri.
- On grant: latch the winner's fields into the request registers, set Owner to the winner, set Pri to the other port (!winner), and go to ACCESS.
- Bad is computed at latch time. Bad = 1 when any of the following holds:
  - Funct3[1:0] == 11
  - Funct3[1:0] == 10 and Addr[1:0] != 0
  - Funct3[1:0] == 01 and Addr[0] != 0
  - Funct3 is 011, 110 or 111
- ACCESS: MemAddr, MemFunct3 and MemWData are driven from the latches.
  - MemWrite = Write & !Bad, combinational from state.
  - At the clock edge: if !Write & !Bad, RData[Owner] <= MemRData. Go to RESP.
- RESP: Ack[Owner] = 1 and Err[Owner] = Bad; go to IDLE.
- Ack and Err are decoded from the state and Owner registers, so they are glitch-free and high for exactly one cycle.
- Outside ACCESS: MemWrite = 0, MemAddr, MemFunct3 and MemWData hold their latched values, and MemRData is ignored.
- A requester drops Req in the cycle after it sees Ack. Because IDLE is entered only after RESP, a Req still high on the Ack cycle is never re-granted.
- A Req that stays high after the cycle following Ack is treated as a new request.
- RDataX holds its value until the next successful load for that port. Stores and rejected accesses leave it unchanged.
- Request inputs are sampled only in IDLE. Changes during ACCESS or RESP have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, Pri = 0, Owner = 0
  - all latches = 0, RData0 = RData1 = 0
  - Ack0/1 = 0, Err0/1 = 0, MemWrite = 0
- Reset asserted during ACCESS:
  - MemWrite drops combinationally, before the next edge, so no memory write occurs.
  - The pending transaction is discarded and never acknowledged.
- Latency: Req is sampled at edge N in IDLE, ACCESS runs in cycle N+1, and Ack is high in cycle N+2.
- The memory write commits at the edge that ends ACCESS.
- Throughput: one transaction per 3 cycles, counting IDLE→ACCESS→RESP. The next grant can occur at the edge ending the IDLE cycle after RESP.
- Sole requester: granted every turn regardless of Pri. Pri still toggles to the other port after each grant.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1…

## Test plan
- Single load, port 0: memory word at 0x40 = 0xDEADBEEF, Req0 with lw at 0x40 → ACCESS one cycle later, Ack0 two cycles after sampling, RData0 = 0xDEADBEEF, Err0 = 0, Ack1 stays 0.
- Store then load, port 1:
  - sw 0x12345678 at 0x80 → MemWrite high exactly one cycle.
  - Then lw at 0x80 → RData1 = 0x12345678.
  - RData0 unchanged throughout.
- Contention: Req0 and Req1 held high for 4 transactions each from reset → grant order 0,1,0,1,…; Ack pulses 3 cycles apart; each Ack one cycle wide.
- Misaligned and illegal accesses:
  - sw at 0x82, lh at 0x41, and funct3 = 011 → each gives Ack with Err = 1 and MemWrite never asserted.
  - After each, a lw at 0x80 still returns the previous contents.
  - RData holds its prior value.
- Reset mid-transaction: assert rst during ACCESS of an sw to 0x90 → MemWrite drops immediately, the word at 0x90 is unchanged, no Ack is issued, all outputs are 0, and the next request after reset is serviced normally with Pri = 0.
- Held Req: port 0 keeps Req0 high one cycle past Ack0 → no duplicate grant; a Req0 held longer is serviced as a second transaction.
